// File: rtl/rx_block_sync_pkg.sv
// Shared definitions for the 64b/66b receive block-lock controller:
// sync header codes, FSM state encoding and header classification.
package rx_block_sync_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Encodings are fixed so PHY-side monitors can decode a probed state value.
    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } sync_state_t;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_sync_sat_cnt16.sv
// Enable-increment 16-bit counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_block_sync.sv
// 64b/66b receive block-lock controller: hunts for sync-header alignment by
// slipping the GT gearbox, then forwards data/header qualified by block lock.
module rx_block_sync
    import rx_block_sync_pkg::*;
#(
    parameter int P_LOCK_CNT  = 64,
    parameter int P_BAD_MAX   = 16,
    parameter int P_SLIP_WAIT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_rx_data,
    input  logic        i_rx_valid,
    input  logic [1:0]  i_rx_header,
    input  logic        i_rx_header_valid,
    output logic        o_rx_slipbit,
    output logic        o_block_lock,
    output logic [63:0] o_rx_data,
    output logic        o_rx_valid,
    output logic [1:0]  o_rx_header,
    output logic        o_rx_header_valid,
    output logic [15:0] o_slip_cnt,
    output logic [15:0] o_lock_loss_cnt
);

    localparam int CW = $clog2((P_LOCK_CNT > P_SLIP_WAIT) ? P_LOCK_CNT : P_SLIP_WAIT) + 1;

    sync_state_t   r_state;
    sync_state_t   w_state_nxt;
    logic [CW-1:0] r_sh_cnt;
    logic [CW-1:0] w_sh_cnt_nxt;
    logic [CW-1:0] r_bad_cnt;
    logic [CW-1:0] w_bad_cnt_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_nxt;
    logic [CW-1:0] w_sh_inc;
    logic [CW-1:0] w_bad_inc;
    logic          w_hdr_ok;
    logic          w_lock;
    logic          w_loss_en;

    logic [63:0]   r_rx_data;
    logic          r_rx_valid;
    logic [1:0]    r_rx_header;
    logic          r_rx_header_valid;

    assign w_hdr_ok  = hdr_is_valid(i_rx_header);
    assign w_lock    = (r_state == ST_LOCKED);
    assign w_sh_inc  = r_sh_cnt + CW'(1);
    assign w_bad_inc = r_bad_cnt + {{(CW-1){1'b0}}, ~w_hdr_ok};

    // NOTE: every signal driven here gets its default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_sh_cnt_nxt   = r_sh_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_loss_en      = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (i_rx_header_valid) begin
                    if (!w_hdr_ok) begin
                        w_state_nxt = ST_SLIP;
                    end else if (w_sh_inc == CW'(P_LOCK_CNT)) begin
                        w_state_nxt  = ST_LOCKED;
                        w_sh_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt = w_sh_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (i_rx_header_valid) begin
                    // Too many bad headers wins over a window closing on the same beat.
                    if (w_bad_inc == CW'(P_BAD_MAX)) begin
                        w_state_nxt = ST_SLIP;
                        w_loss_en   = 1'b1;
                    end else if (w_sh_inc == CW'(P_LOCK_CNT)) begin
                        w_sh_cnt_nxt  = '0;
                        w_bad_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt  = w_sh_inc;
                        w_bad_cnt_nxt = w_bad_inc;
                    end
                end
            end
            ST_SLIP: begin
                w_state_nxt    = ST_SLIP_WAIT;
                w_sh_cnt_nxt   = '0;
                w_bad_cnt_nxt  = '0;
                w_wait_cnt_nxt = '0;
            end
            ST_SLIP_WAIT: begin
                if (i_rx_header_valid) begin
                    if (r_wait_cnt == CW'(P_SLIP_WAIT - 1)) begin
                        w_state_nxt    = ST_HUNT;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_HUNT;
            r_sh_cnt   <= '0;
            r_bad_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_cnt   <= w_sh_cnt_nxt;
            r_bad_cnt  <= w_bad_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Valid qualifiers use the lock held while the input is sampled.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_data         <= '0;
            r_rx_valid        <= 1'b0;
            r_rx_header       <= '0;
            r_rx_header_valid <= 1'b0;
        end else begin
            r_rx_data         <= i_rx_data;
            r_rx_valid        <= i_rx_valid & w_lock;
            r_rx_header       <= i_rx_header;
            r_rx_header_valid <= i_rx_header_valid & w_lock;
        end
    end

    sat_cnt16 u_slip_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (r_state == ST_SLIP),
        .o_cnt (o_slip_cnt)
    );

    sat_cnt16 u_lock_loss_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_loss_en),
        .o_cnt (o_lock_loss_cnt)
    );

    assign o_rx_slipbit      = (r_state == ST_SLIP);
    assign o_block_lock      = w_lock;
    assign o_rx_data         = r_rx_data;
    assign o_rx_valid        = r_rx_valid;
    assign o_rx_header       = r_rx_header;
    assign o_rx_header_valid = r_rx_header_valid;

endmodule

// File: tb/tb_rx_block_sync.sv
// Self-checking bench for rx_block_sync: a beat-level reference model pushes
// expected outputs to a scoreboard queue, popped and compared after each edge.
module tb_rx_block_sync;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [63:0] i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic [1:0]  i_rx_header = '0;
    logic        i_rx_header_valid = 1'b0;
    logic        o_rx_slipbit;
    logic        o_block_lock;
    logic [63:0] o_rx_data;
    logic        o_rx_valid;
    logic [1:0]  o_rx_header;
    logic        o_rx_header_valid;
    logic [15:0] o_slip_cnt;
    logic [15:0] o_lock_loss_cnt;

    rx_block_sync dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_rx_data         (i_rx_data),
        .i_rx_valid        (i_rx_valid),
        .i_rx_header       (i_rx_header),
        .i_rx_header_valid (i_rx_header_valid),
        .o_rx_slipbit      (o_rx_slipbit),
        .o_block_lock      (o_block_lock),
        .o_rx_data         (o_rx_data),
        .o_rx_valid        (o_rx_valid),
        .o_rx_header       (o_rx_header),
        .o_rx_header_valid (o_rx_header_valid),
        .o_slip_cnt        (o_slip_cnt),
        .o_lock_loss_cnt   (o_lock_loss_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] data;
        logic        valid;
        logic [1:0]  hdr;
        logic        hv;
        logic        lock;
        logic        slip;
        logic [15:0] slips;
        logic [15:0] loss;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0 hunt, 1 locked, 2 slip, 3 slip wait.
    int m_st, m_sh, m_bad, m_wait, m_slips, m_loss;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sh = 0; m_bad = 0; m_wait = 0; m_slips = 0; m_loss = 0;
    endtask

    task automatic model_step(input logic hv, input logic [1:0] hdr, input logic dv,
                              input logic [63:0] data, output exp_t e);
        logic good;
        good    = (hdr == 2'b01) || (hdr == 2'b10);
        e.data  = data;
        e.hdr   = hdr;
        e.valid = dv && (m_st == 1);
        e.hv    = hv && (m_st == 1);
        case (m_st)
            0: if (hv) begin
                if (!good) m_st = 2;
                else begin
                    m_sh++;
                    if (m_sh == 64) begin m_st = 1; m_sh = 0; end
                end
            end
            1: if (hv) begin
                m_sh++;
                if (!good) m_bad++;
                if (m_bad == 16) begin
                    m_st = 2;
                    if (m_loss < 65535) m_loss++;
                end else if (m_sh == 64) begin
                    m_sh = 0; m_bad = 0;
                end
            end
            2: begin
                if (m_slips < 65535) m_slips++;
                m_sh = 0; m_bad = 0; m_wait = 0; m_st = 3;
            end
            default: if (hv) begin
                m_wait++;
                if (m_wait == 32) begin m_st = 0; m_wait = 0; end
            end
        endcase
        e.lock  = (m_st == 1);
        e.slip  = (m_st == 2);
        e.slips = 16'(m_slips);
        e.loss  = 16'(m_loss);
    endtask

    task automatic beat(input logic hv, input logic [1:0] hdr, input logic dv, input logic [63:0] data);
        exp_t e;
        @(negedge i_clk);
        i_rx_header_valid = hv;
        i_rx_header       = hdr;
        i_rx_valid        = dv;
        i_rx_data         = data;
        model_step(hv, hdr, dv, data, e);
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        e = sb_q.pop_front();
        chk("data",      o_rx_data,         e.data);
        chk("valid",     o_rx_valid,        e.valid);
        chk("header",    o_rx_header,       e.hdr);
        chk("hdr_valid", o_rx_header_valid, e.hv);
        chk("lock",      o_block_lock,      e.lock);
        chk("slipbit",   o_rx_slipbit,      e.slip);
        chk("slip_cnt",  o_slip_cnt,        e.slips);
        chk("loss_cnt",  o_lock_loss_cnt,   e.loss);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_slipbit"},   o_rx_slipbit,      1'b0);
        chk({tag, "_lock"},      o_block_lock,      1'b0);
        chk({tag, "_data"},      o_rx_data,         64'h0);
        chk({tag, "_valid"},     o_rx_valid,        1'b0);
        chk({tag, "_header"},    o_rx_header,       2'b00);
        chk({tag, "_hdr_valid"}, o_rx_header_valid, 1'b0);
        chk({tag, "_slip_cnt"},  o_slip_cnt,        16'h0);
        chk({tag, "_loss_cnt"},  o_lock_loss_cnt,   16'h0);
    endtask

    // Asserts reset between edges so the outputs must clear without a clock.
    task automatic async_reset(input string tag);
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        #1 check_all_zero(tag);
        sb_q.delete();
        model_reset();
        i_rx_header_valid = 1'b0;
        i_rx_valid        = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    initial begin
        logic [1:0] h;
        model_reset();
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b1;

        // Clean headers from reset: lock right after the 64th.
        for (int i = 0; i < 64; i++) beat(1'b1, 2'b01, 1'b1, rnd64());
        chk("t1_lock", o_block_lock, 1'b1);
        chk("t1_slip_cnt", o_slip_cnt, 16'd0);

        // 15 bad headers in one window keep lock; 16 in the next drop it.
        for (int i = 0; i < 64; i++) beat(1'b1, (i < 15) ? 2'b11 : 2'b10, 1'b1, rnd64());
        chk("t3_keep_lock", o_block_lock, 1'b1);
        for (int i = 0; i < 16; i++) beat(1'b1, 2'b00, 1'b1, rnd64());
        chk("t3_lock_drop", o_block_lock, 1'b0);
        chk("t3_slipbit", o_rx_slipbit, 1'b1);
        chk("t3_loss_cnt", o_lock_loss_cnt, 16'd1);
        beat(1'b1, 2'b01, 1'b1, rnd64());
        chk("t3_slip_single", o_rx_slipbit, 1'b0);
        chk("t3_slip_cnt", o_slip_cnt, 16'd1);
        for (int i = 0; i < 32; i++) begin
            h = 2'($urandom_range(0, 3));
            beat(1'b1, h, 1'b1, rnd64());
        end
        for (int i = 0; i < 64; i++) beat(1'b1, 2'b10, 1'b1, rnd64());
        chk("t3_relock", o_block_lock, 1'b1);

        // 16th bad header coincides with the window's 64th header.
        for (int i = 0; i < 64; i++) beat(1'b1, (i < 48) ? 2'b01 : 2'b11, 1'b1, rnd64());
        chk("t4_lock_drop", o_block_lock, 1'b0);
        chk("t4_slipbit", o_rx_slipbit, 1'b1);
        chk("t4_loss_cnt", o_lock_loss_cnt, 16'd2);

        // Reset while in SLIP_WAIT.
        for (int i = 0; i < 6; i++) beat(1'b1, 2'b01, 1'b1, rnd64());
        async_reset("t6");

        // Bad header at beat 10 in HUNT, 32 ignored beats, then a clean window.
        for (int i = 0; i < 9; i++) beat(1'b1, 2'b01, 1'b1, rnd64());
        beat(1'b1, 2'b11, 1'b1, rnd64());
        chk("t2_slipbit", o_rx_slipbit, 1'b1);
        beat(1'b0, 2'b00, 1'b0, rnd64());
        for (int i = 0; i < 32; i++) begin
            h = 2'($urandom_range(0, 3));
            beat(1'b1, h, 1'b1, rnd64());
        end
        for (int i = 0; i < 63; i++) beat(1'b1, 2'b01, 1'b1, rnd64());
        chk("t2_no_lock_yet", o_block_lock, 1'b0);
        beat(1'b1, 2'b01, 1'b1, rnd64());
        chk("t2_lock", o_block_lock, 1'b1);
        chk("t2_slip_cnt", o_slip_cnt, 16'd1);

        // Header valid on one cycle in three with random data valid.
        async_reset("t5_reset");
        for (int i = 0; i < 192; i++)
            beat((i % 3) == 0, 2'b10, 1'($urandom_range(0, 1)), rnd64());
        chk("t5_lock", o_block_lock, 1'b1);
        chk("t5_slip_cnt", o_slip_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
